// File: rtl/can_pkg.sv
// Shared types and timing helpers for the CAN receive bit path.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package can_pkg;

  typedef enum logic [1:0] {
    INTEGRATE = 2'd0,
    IDLE      = 2'd1,
    SOF_CHK   = 2'd2,
    RX        = 2'd3
  } can_rx_state_e;

  // Five equal bits in a row force a complementary stuff bit.
  localparam int unsigned CAN_STUFF_LIMIT = 5;

  // System clocks per CAN bit.
  function automatic int unsigned can_bit_clks(input int unsigned clk_mhz,
                                               input int unsigned rate_kbits);
    return (clk_mhz * 1000) / rate_kbits;
  endfunction

  // Counter value at which the bit is sampled (just before mid-bit).
  function automatic int unsigned can_sample_pt(input int unsigned bit_clks);
    return bit_clks / 2 - 1;
  endfunction

endpackage

// File: rtl/can_bit_timer.sv
// Bit timer: rx synchronizer, falling-edge detect, per-bit counter and sample strobe.
// Latency: din reaches din_s after 2 clk; sample fires while cnt == SAMPLE_PT.
// Backpressure: none; free-running. CAN_RX_RESYNC_EN adds a soft resync on falling edges.
module can_bit_timer #(
  parameter int unsigned BIT_CLKS  = 100,
  parameter int unsigned SAMPLE_PT = 49
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic hold,
  input  logic hard_sync,
  input  logic resync_en,
  output logic din_s,
  output logic fall,
  output logic sample
);

  localparam int unsigned CNT_W = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_SP  = CNT_W'(SAMPLE_PT);

  logic             sync1_q, sync1_d;
  logic             din_s_q, din_s_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resync;

  assign din_s  = din_s_q;
  assign fall   = prev_q & ~din_s_q;
  assign sample = (cnt_q == CNT_SP);

`ifdef CAN_RX_RESYNC_EN
  logic sampled_q, sampled_d;
  logic resynced_q, resynced_d;

  // Soft resync: only once per bit, only before that bit's sample, never at the bit boundary.
  always_comb begin
    resync = resync_en & fall & ~sample & (cnt_q != '0) & (cnt_q != CNT_MAX)
             & ~sampled_q & ~resynced_q;
    sampled_d  = sampled_q;
    resynced_d = resynced_q;
    if (hard_sync || hold || (cnt_q == CNT_MAX)) begin
      sampled_d  = 1'b0;
      resynced_d = 1'b0;
    end else begin
      if (sample) sampled_d  = 1'b1;
      if (resync) resynced_d = 1'b1;
    end
  end

  // Per-bit resync bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sampled_q  <= 1'b0;
      resynced_q <= 1'b0;
    end else begin
      sampled_q  <= sampled_d;
      resynced_q <= resynced_d;
    end
  end
`else
  logic unused_resync_en;
  assign unused_resync_en = resync_en;

  // Without soft resync only the SOF hard sync aligns the counter.
  always_comb begin
    resync = 1'b0;
  end
`endif

  // Next-state for synchronizer and counter; the edge cycle counts as cnt 0.
  always_comb begin
    sync1_d = din;
    din_s_d = sync1_q;
    prev_d  = din_s_q;
    if (hard_sync || resync) begin
      cnt_d = CNT_W'(1);
    end else if (hold) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchronizer resets recessive so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      din_s_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      din_s_q <= din_s_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/can_rx_bit_ctrl.sv
// CAN rx bit controller: bus integration, SOF hard sync, mid-bit sampling, destuffing.
// Latency: bit_valid one clk after the sample; SOF strobe 52 clk after the din edge at defaults.
// Backpressure: none; decoder must take every strobe. CAN_RX_RESYNC_EN enables soft resync.
module can_rx_bit_ctrl
  import can_pkg::*;
#(
  parameter int unsigned clk_speed_MHz      = 100,
  parameter int unsigned can_bit_rate_Kbits = 1000,
  parameter int unsigned idle_bits          = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic frame_done,
  output logic bit_valid,
  output logic bit_data,
  output logic sof,
  output logic stuff_err,
  output logic busy
);

  localparam int unsigned BIT_CLKS  = can_bit_clks(clk_speed_MHz, can_bit_rate_Kbits);
  localparam int unsigned SAMPLE_PT = can_sample_pt(BIT_CLKS);
  localparam int unsigned IDLE_W    = $clog2(idle_bits + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(idle_bits - 1);
  localparam logic [2:0] STUFF_MAX = 3'(CAN_STUFF_LIMIT);

  can_rx_state_e     state_q, state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [2:0]        stuff_cnt_q, stuff_cnt_d;
  logic              last_q, last_d;
  logic              bit_valid_q, bit_valid_d;
  logic              bit_data_q, bit_data_d;
  logic              sof_q, sof_d;
  logic              stuff_err_q, stuff_err_d;
  logic              busy_q, busy_d;

  logic din_s, fall, sample;
  logic in_idle;

  assign in_idle = (state_q == IDLE);

  can_bit_timer #(
    .BIT_CLKS  (BIT_CLKS),
    .SAMPLE_PT (SAMPLE_PT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .hold      (in_idle),
    .hard_sync (in_idle & fall),
    .resync_en (state_q == RX),
    .din_s     (din_s),
    .fall      (fall),
    .sample    (sample)
  );

  assign bit_valid = bit_valid_q;
  assign bit_data  = bit_data_q;
  assign sof       = sof_q;
  assign stuff_err = stuff_err_q;
  assign busy      = busy_q;

  // Receive FSM and destuffer next-state; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    stuff_cnt_d = stuff_cnt_q;
    last_d      = last_q;
    bit_valid_d = 1'b0;
    bit_data_d  = 1'b0;
    sof_d       = 1'b0;
    stuff_err_d = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      INTEGRATE: begin
        if (sample) begin
          if (din_s) begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_d    = IDLE;
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
          end else begin
            idle_cnt_d = '0;
          end
        end
      end
      IDLE: begin
        if (fall) state_d = SOF_CHK;
      end
      SOF_CHK: begin
        if (sample) begin
          if (!din_s) begin
            bit_valid_d = 1'b1;
            sof_d       = 1'b1;
            stuff_cnt_d = 3'd1;
            last_d      = 1'b0;
            busy_d      = 1'b1;
            state_d     = RX;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RX: begin
        // frame_done wins over a coincident sample, which is dropped.
        if (frame_done) begin
          busy_d     = 1'b0;
          state_d    = INTEGRATE;
          idle_cnt_d = '0;
        end else if (sample) begin
          if (stuff_cnt_q == STUFF_MAX) begin
            if (din_s != last_q) begin
              last_d      = din_s;
              stuff_cnt_d = 3'd1;
            end else begin
              stuff_err_d = 1'b1;
              busy_d      = 1'b0;
              state_d     = INTEGRATE;
              idle_cnt_d  = '0;
            end
          end else begin
            bit_valid_d = 1'b1;
            bit_data_d  = din_s;
            stuff_cnt_d = (din_s == last_q) ? stuff_cnt_q + 3'd1 : 3'd1;
            last_d      = din_s;
          end
        end
      end
      default: state_d = INTEGRATE;
    endcase
  end

  // State and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INTEGRATE;
      idle_cnt_q  <= '0;
      stuff_cnt_q <= '0;
      last_q      <= 1'b1;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      sof_q       <= 1'b0;
      stuff_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      stuff_cnt_q <= stuff_cnt_d;
      last_q      <= last_d;
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
      sof_q       <= sof_d;
      stuff_err_q <= stuff_err_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_can_rx_bit_ctrl.sv
// Directed bench for can_rx_bit_ctrl with an expected-bit queue drained on each bit_valid.
// Latency: n/a.
// Backpressure: n/a.
module tb_can_rx_bit_ctrl;
  import can_pkg::*;

  logic clk = 1'b0;
  logic rst, din, frame_done;
  logic bit_valid, bit_data, sof, stuff_err, busy;

  int n_checks = 0;
  int n_pass   = 0;
  int bv_cnt   = 0;
  int se_cnt   = 0;
  int bv0, se0, lat;
  logic [1:0] exp_q[$];   // {sof, data}

  always #5 clk = ~clk;

  can_rx_bit_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .frame_done (frame_done),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .sof        (sof),
    .stuff_err  (stuff_err),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int len);
    din = b;
    tick(len);
  endtask

  task automatic push(input logic s, input logic d);
    exp_q.push_back({s, d});
  endtask

  // Scoreboard: every strobe must match the oldest expected bit.
  always @(negedge clk) begin
    logic [1:0] e;
    if (stuff_err === 1'b1) se_cnt++;
    if (bit_valid === 1'b1) begin
      bv_cnt++;
      check("bit_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bit_data", 32'(bit_data), 32'(e[0]));
        check("bit_sof", 32'(sof), 32'(e[1]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    din = 1'b1;
    frame_done = 1'b0;
    tick(3);
    check("rst_bit_valid", 32'(bit_valid), 0);
    check("rst_bit_data", 32'(bit_data), 0);
    check("rst_sof", 32'(sof), 0);
    check("rst_stuff_err", 32'(stuff_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dut.state_q), 32'(INTEGRATE));
    rst = 1'b0;

    // Bus integration: 11 recessive bits
    tick(1100);
    check("integ_busy", 32'(busy), 0);
    check("integ_state", 32'(dut.state_q), 32'(IDLE));

    // SOF latency and destuffing: 0 0 0 0 0 [1] 1 0
    push(1'b1, 1'b0);
    repeat (4) push(1'b0, 1'b0);
    push(1'b0, 1'b1);
    push(1'b0, 1'b0);
    bv0 = bv_cnt;
    se0 = se_cnt;
    lat = 0;
    din = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bit_valid === 1'b1 && lat == 0) lat = i;
    end
    check("sof_latency", 32'(lat), 52);
    drive_bit(1'b0, 100);
    drive_bit(1'b0, 100);
    drive_bit(1'b0, 100);
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 100);
    drive_bit(1'b1, 100);
    drive_bit(1'b0, 100);
    check("rx_busy", 32'(busy), 1);
    din = 1'b1;
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
    tick(1);
    check("fd_busy", 32'(busy), 0);
    check("fd_state", 32'(dut.state_q), 32'(INTEGRATE));
    check("destuff_bv_count", 32'(bv_cnt - bv0), 7);
    check("destuff_no_err", 32'(se_cnt - se0), 0);

    // Dominant glitch in IDLE
    tick(1200);
    check("pre_glitch_state", 32'(dut.state_q), 32'(IDLE));
    bv0 = bv_cnt;
    din = 1'b0;
    tick(20);
    din = 1'b1;
    tick(120);
    check("glitch_bv_count", 32'(bv_cnt - bv0), 0);
    check("glitch_busy", 32'(busy), 0);
    check("glitch_state", 32'(dut.state_q), 32'(IDLE));

    // Six dominant bits: stuff error on the sixth sample
    push(1'b1, 1'b0);
    repeat (4) push(1'b0, 1'b0);
    bv0 = bv_cnt;
    se0 = se_cnt;
    drive_bit(1'b0, 600);
    check("serr_count", 32'(se_cnt - se0), 1);
    check("serr_bv_count", 32'(bv_cnt - bv0), 5);
    check("serr_busy", 32'(busy), 0);
    check("serr_state", 32'(dut.state_q), 32'(INTEGRATE));
    bv0 = bv_cnt;
    drive_bit(1'b1, 500);
    check("reinteg_not_idle", 32'(dut.state_q), 32'(INTEGRATE));
    drive_bit(1'b0, 100);
    check("early_sof_ignored", 32'(bv_cnt - bv0), 0);
    drive_bit(1'b1, 1200);
    check("reinteg_idle", 32'(dut.state_q), 32'(IDLE));

    // frame_done coincident with the sample of the third bit
    push(1'b1, 1'b0);
    push(1'b0, 1'b1);
    bv0 = bv_cnt;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 100);
    din = 1'b0;
    tick(51);
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
    check("fdc_bit_valid", 32'(bit_valid), 0);
    check("fdc_busy", 32'(busy), 0);
    check("fdc_state", 32'(dut.state_q), 32'(INTEGRATE));
    check("fdc_bv_count", 32'(bv_cnt - bv0), 2);

    // Reset mid-frame, landing on a would-be strobe
    drive_bit(1'b1, 1200);
    check("pre_rst_state", 32'(dut.state_q), 32'(IDLE));
    push(1'b1, 1'b0);
    drive_bit(1'b0, 100);
    din = 1'b1;
    tick(51);
    check("mid_frame_busy", 32'(busy), 1);
    rst = 1'b1;
    tick(1);
    check("mrst_bit_valid", 32'(bit_valid), 0);
    check("mrst_bit_data", 32'(bit_data), 0);
    check("mrst_sof", 32'(sof), 0);
    check("mrst_stuff_err", 32'(stuff_err), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_state", 32'(dut.state_q), 32'(INTEGRATE));
    rst = 1'b0;

`ifdef CAN_RX_RESYNC_EN
    // Bits 10 clk long over nominal: soft resync keeps every sample aligned
    drive_bit(1'b1, 1200);
    check("pre_resync_state", 32'(dut.state_q), 32'(IDLE));
    bv0 = bv_cnt;
    for (int i = 0; i < 9; i++) push(i == 0, 1'(i % 2));
    for (int i = 0; i < 9; i++) drive_bit(1'(i % 2), 110);
    din = 1'b1;
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
    tick(1);
    check("resync_bv_count", 32'(bv_cnt - bv0), 9);
    check("resync_busy", 32'(busy), 0);
`endif

    tick(5);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
